// File: rtl/dnn_mac_scheduler_pkg.sv
// Shared types and constants for the dot-product accelerator batch scheduler.
package dnn_sched_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_FULL = 3'd2,
      TRIGGER   = 3'd3,
      READ      = 3'd4
   } sched_state_t;

   localparam int BATCH_LEN = 64;
   localparam int IDX_W     = 6;
   localparam int RES_W     = 32;
   localparam int VEC_W     = 64;

   // Width needed to hold values 0..n-1, never less than one bit.
   function automatic int clog2Min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dnn_mac_scheduler_if.sv
// Scheduler <-> dnn_accelerator link: job issue, drain handshake and result read-back.
interface dnn_mac_scheduler_if;
   import dnn_sched_pkg::*;

   logic             EN_mac;
   logic [VEC_W-1:0] mac_vecA;
   logic [VEC_W-1:0] mac_vecB;
   logic             RDY_mac;
   logic             EN_readMem;
   logic             VALID_memVal;
   logic [RES_W-1:0] memVal_data;

   modport master (
      output EN_mac, mac_vecA, mac_vecB, EN_readMem,
      input  RDY_mac, VALID_memVal, memVal_data
   );

   modport slave (
      input  EN_mac, mac_vecA, mac_vecB, EN_readMem,
      output RDY_mac, VALID_memVal, memVal_data
   );

endinterface

// File: rtl/dnn_mac_scheduler_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr wins; one-hot grant plus index.
module dnn_rr_arbiter
   import dnn_sched_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = clog2Min1(N)
)(
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   int   pos_s;
   logic found_s;

   // Rotating priority search starting at ptr (ptr is always below N).
   always_comb begin
      gnt     = {N{1'b0}};
      gnt_idx = {IW{1'b0}};
      found_s = 1'b0;
      pos_s   = 0;
      for (int k = 0; k < N; k++) begin
         pos_s = int'(ptr) + k;
         if (pos_s >= N) begin
            pos_s = pos_s - N;
         end else begin
            pos_s = pos_s;
         end
         if (en && !found_s && req[pos_s]) begin
            gnt[pos_s] = 1'b1;
            gnt_idx    = IW'(pos_s);
            found_s    = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/dnn_mac_scheduler.sv
// Batch scheduler: round-robin issue of 64 tagged MAC jobs, then read-back of the tagged results.
module dnn_mac_scheduler
   import dnn_sched_pkg::*;
#(
   parameter int  NUM_REQ       = 2,
   parameter int  MIN_ISSUE_GAP = 1,
   parameter int  DRAIN_TIMEOUT = 256,
   localparam int ID_W          = clog2Min1(NUM_REQ)
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*VEC_W-1:0] req_vecA,
   input  logic [NUM_REQ*VEC_W-1:0] req_vecB,
   output logic [NUM_REQ-1:0]       req_ready,
   dnn_mac_scheduler_if.master      acc,
   output logic                     res_valid,
   output logic [RES_W-1:0]         res_data,
   output logic [ID_W-1:0]          res_req_id,
   output logic [IDX_W-1:0]         res_index,
   output logic                     busy,
   output logic                     batch_done,
   output logic                     err_timeout
);

   localparam int GAP_W = clog2Min1(MIN_ISSUE_GAP);
   localparam int TO_W  = clog2Min1(DRAIN_TIMEOUT);

   sched_state_t     state_r, stateNext_s;
   logic [6:0]       issueCnt_r;
   logic [5:0]       rdCnt_r;
   logic [GAP_W-1:0] gapCnt_r;
   logic [TO_W-1:0]  waitCnt_r;
   logic [ID_W-1:0]  ptr_r;
   logic [ID_W-1:0]  tagMem_r [BATCH_LEN];
   logic             enMac_r, enReadMem_r, donePend_r;
   logic [VEC_W-1:0] macVecA_r, macVecB_r, selVecA_s, selVecB_s;
   logic [NUM_REQ-1:0] gnt_s;
   logic [ID_W-1:0]  gntIdx_s;
   logic             grantEn_s, accept_s, lastIssue_s, beat_s, lastBeat_s;

   assign grantEn_s   = (state_r == ISSUE) && acc.RDY_mac && (gapCnt_r == {GAP_W{1'b0}}) && !issueCnt_r[6];
   assign accept_s    = |(gnt_s & req_valid);
   assign lastIssue_s = accept_s && (issueCnt_r == 7'd63);
   assign beat_s      = (state_r == READ) && acc.VALID_memVal;
   assign lastBeat_s  = beat_s && (rdCnt_r == 6'd63);

   assign req_ready      = gnt_s;
   assign acc.EN_mac     = enMac_r;
   assign acc.mac_vecA   = macVecA_r;
   assign acc.mac_vecB   = macVecB_r;
   assign acc.EN_readMem = enReadMem_r;

   dnn_rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
      .req     (req_valid),
      .ptr     (ptr_r),
      .en      (grantEn_s),
      .gnt     (gnt_s),
      .gnt_idx (gntIdx_s)
   );

   // Operand mux for the granted requester.
   always_comb begin
      selVecA_s = {VEC_W{1'b0}};
      selVecB_s = {VEC_W{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_s[i]) begin
            selVecA_s = req_vecA[i*VEC_W +: VEC_W];
            selVecB_s = req_vecB[i*VEC_W +: VEC_W];
         end else begin
            selVecA_s = selVecA_s;
            selVecB_s = selVecB_s;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      stateNext_s = state_r;
      case (state_r)
         IDLE:      if (|req_valid)   stateNext_s = ISSUE;     else stateNext_s = IDLE;
         ISSUE:     if (lastIssue_s)  stateNext_s = WAIT_FULL; else stateNext_s = ISSUE;
         WAIT_FULL: if (!acc.RDY_mac) stateNext_s = TRIGGER;   else stateNext_s = WAIT_FULL;
         TRIGGER:   stateNext_s = READ;
         READ:      if (lastBeat_s)   stateNext_s = IDLE;      else stateNext_s = READ;
         default:   stateNext_s = IDLE;
      endcase
   end

   // State register plus status flags decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         busy        <= 1'b0;
         enReadMem_r <= 1'b0;
      end else begin
         state_r     <= stateNext_s;
         busy        <= (stateNext_s != IDLE);
         enReadMem_r <= (stateNext_s == TRIGGER);
      end
   end

   // Issue path: pointer, spacing counter, job counter and the registered job to the accelerator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r      <= {ID_W{1'b0}};
         gapCnt_r   <= {GAP_W{1'b0}};
         issueCnt_r <= 7'd0;
         enMac_r    <= 1'b0;
         macVecA_r  <= {VEC_W{1'b0}};
         macVecB_r  <= {VEC_W{1'b0}};
      end else begin
         enMac_r <= accept_s;
         if (accept_s) begin
            ptr_r      <= (gntIdx_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : gntIdx_s + {{(ID_W-1){1'b0}}, 1'b1};
            gapCnt_r   <= GAP_W'(MIN_ISSUE_GAP - 1);
            issueCnt_r <= issueCnt_r + 7'd1;
            macVecA_r  <= selVecA_s;
            macVecB_r  <= selVecB_s;
         end else begin
            if (gapCnt_r != {GAP_W{1'b0}}) begin
               gapCnt_r <= gapCnt_r - {{(GAP_W-1){1'b0}}, 1'b1};
            end
            if (lastBeat_s) begin
               issueCnt_r <= 7'd0;
            end
         end
      end
   end

   // Owner tag per batch slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BATCH_LEN; i++) begin
            tagMem_r[i] <= {ID_W{1'b0}};
         end
      end else if (accept_s) begin
         tagMem_r[issueCnt_r[5:0]] <= gntIdx_s;
      end
   end

   // Drain watchdog; the flag only clears on reset and the FSM keeps waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waitCnt_r   <= {TO_W{1'b0}};
         err_timeout <= 1'b0;
      end else if (state_r == WAIT_FULL) begin
         if (waitCnt_r == TO_W'(DRAIN_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
         end else begin
            waitCnt_r <= waitCnt_r + {{(TO_W-1){1'b0}}, 1'b1};
         end
      end else begin
         waitCnt_r <= {TO_W{1'b0}};
      end
   end

   // Read-back: each beat in READ becomes one tagged result a cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdCnt_r    <= 6'd0;
         res_valid  <= 1'b0;
         res_data   <= {RES_W{1'b0}};
         res_req_id <= {ID_W{1'b0}};
         res_index  <= {IDX_W{1'b0}};
         donePend_r <= 1'b0;
         batch_done <= 1'b0;
      end else begin
         res_valid  <= beat_s;
         donePend_r <= lastBeat_s;
         batch_done <= donePend_r;
         if (beat_s) begin
            res_data   <= acc.memVal_data;
            res_req_id <= tagMem_r[rdCnt_r];
            res_index  <= rdCnt_r;
            rdCnt_r    <= lastBeat_s ? 6'd0 : rdCnt_r + 6'd1;
         end
      end
   end

endmodule

// File: tb/tb_dnn_mac_scheduler.sv
// Randomized directed bench for dnn_mac_scheduler against a round-robin / dot-product reference model.
module tb_dnn_mac_scheduler;
   import dnn_sched_pkg::*;

   localparam int N    = 3;
   localparam int GAP  = 2;
   localparam int DTO  = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N-1:0]       rv;
   logic [N*64-1:0]    va, vb;
   logic [N-1:0]       req_ready;
   logic               res_valid, busy, batch_done, err_timeout;
   logic [31:0]        res_data;
   logic [1:0]         res_req_id;
   logic [5:0]         res_index;

   dnn_mac_scheduler_if acc ();

   dnn_mac_scheduler #(.NUM_REQ(N), .MIN_ISSUE_GAP(GAP), .DRAIN_TIMEOUT(DTO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (rv),
      .req_vecA    (va),
      .req_vecB    (vb),
      .req_ready   (req_ready),
      .acc         (acc.master),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .res_req_id  (res_req_id),
      .res_index   (res_index),
      .busy        (busy),
      .batch_done  (batch_done),
      .err_timeout (err_timeout)
   );

   int vectors = 0;
   int errors  = 0;

   // Reference model state
   int          cyc = 0;
   int          mPtr, accCnt, issCnt, rdCnt, readCnt, doneCnt, lastAcc;
   bit          pendFlag, doneDue, exactGap;
   logic [63:0] pendA, pendB;
   logic [31:0] accVal [64];
   logic [1:0]  expId  [64];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dot(input logic [63:0] a, input logic [63:0] b);
      logic [31:0] s = 32'd0;
      for (int i = 0; i < 4; i++) s += 32'(a[16*i +: 16]) * 32'(b[16*i +: 16]);
      return s;
   endfunction

   task automatic modelReset();
      mPtr = 0; accCnt = 0; issCnt = 0; rdCnt = 0; lastAcc = -100;
      pendFlag = 1'b0; doneDue = 1'b0;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares every grant, issue and result against the model.
   always @(negedge clk) begin
      int e, p;
      logic [N-1:0] oh;
      if (rst_n) begin
         if (pendFlag || acc.EN_mac) begin
            check("en_mac_latency", 64'(acc.EN_mac), 64'(pendFlag));
            if (pendFlag) begin
               check("mac_vecA", acc.mac_vecA, pendA);
               check("mac_vecB", acc.mac_vecB, pendB);
               if (issCnt < 64) accVal[issCnt] = dot(pendA, pendB);
               issCnt++;
            end
         end
         pendFlag = 1'b0;
         if (!acc.RDY_mac) check("stall_no_grant", 64'(req_ready), 64'd0);
         if (req_ready != '0) begin
            e = -1;
            for (int k = 0; k < N; k++) begin
               p = (mPtr + k) % N;
               if (e < 0 && rv[p]) e = p;
            end
            oh = '0;
            if (e >= 0) oh[e] = 1'b1;
            check("rr_grant", 64'(req_ready), 64'(oh));
            check("gap_min", 64'(cyc - lastAcc >= GAP), 64'd1);
            if (exactGap && accCnt > 0) check("gap_exact", 64'(cyc - lastAcc), 64'(GAP));
            check("issue_bound", 64'(accCnt < 64), 64'd1);
            if (e >= 0 && accCnt < 64) begin
               expId[accCnt] = 2'(e);
               pendA = va[e*64 +: 64];
               pendB = vb[e*64 +: 64];
               pendFlag = 1'b1;
               mPtr = (e + 1) % N;
            end
            lastAcc = cyc;
            accCnt++;
         end
         if (doneDue || batch_done) begin
            check("batch_done", 64'(batch_done), 64'(doneDue));
            if (batch_done) doneCnt++;
         end
         doneDue = 1'b0;
         if (res_valid) begin
            check("res_in_batch", 64'(rdCnt < 64), 64'd1);
            if (rdCnt < 64) begin
               check("res_data",   64'(res_data),   64'(accVal[rdCnt]));
               check("res_req_id", 64'(res_req_id), 64'(expId[rdCnt]));
               check("res_index",  64'(res_index),  64'(rdCnt));
            end
            rdCnt++;
            if (rdCnt == 64) doneDue = 1'b1;
         end
         if (acc.EN_readMem) readCnt++;
      end
   end

   task automatic driveVecs(input bit ones);
      for (int i = 0; i < N; i++) begin
         va[i*64 +: 64] = ones ? 64'h0001_0001_0001_0001 : {$urandom, $urandom};
         vb[i*64 +: 64] = ones ? 64'h0001_0001_0001_0001 : {$urandom, $urandom};
      end
   endtask

   task automatic issuePhase(input bit allValid, input bit doStall, input int stopAt);
      bit stalled = 1'b0;
      int r0;
      exactGap = allValid;
      acc.RDY_mac = 1'b1;
      for (int c = 0; c < 2000 && accCnt < stopAt; c++) begin
         @(posedge clk); #1;
         rv = allValid ? {N{1'b1}} : N'($urandom_range(0, 7));
         driveVecs(allValid);
         if (doStall && !stalled && accCnt >= 30) begin
            stalled = 1'b1;
            acc.RDY_mac = 1'b0;
            r0 = rdCnt;
            acc.VALID_memVal = 1'b1;
            acc.memVal_data  = $urandom;
            repeat (10) begin
               @(posedge clk); #1;
               acc.VALID_memVal = 1'b0;
               rv = {N{1'b1}};
            end
            check("stray_beat_ignored", 64'(rdCnt), 64'(r0));
            acc.RDY_mac = 1'b1;
         end
      end
      check("issue_count", 64'(accCnt), 64'(stopAt));
   endtask

   task automatic drainAndRead();
      int r0, d0;
      rv = '0;
      r0 = readCnt;
      d0 = doneCnt;
      repeat (3) @(posedge clk);
      #1 acc.RDY_mac = 1'b0;
      for (int c = 0; c < 40 && readCnt == r0; c++) @(negedge clk);
      check("en_readmem_seen", 64'(readCnt), 64'(r0 + 1));
      @(posedge clk); #1;
      for (int k = 0; k < 64; k++) begin
         acc.VALID_memVal = 1'b1;
         acc.memVal_data  = accVal[k];
         @(posedge clk); #1;
         acc.VALID_memVal = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      for (int c = 0; c < 10 && doneCnt == d0; c++) @(negedge clk);
      check("done_once", 64'(doneCnt), 64'(d0 + 1));
      check("issued_64", 64'(issCnt), 64'd64);
      check("results_64", 64'(rdCnt), 64'd64);
      check("readmem_once", 64'(readCnt), 64'(r0 + 1));
      check("busy_after", 64'(busy), 64'd0);
      check("no_timeout", 64'(err_timeout), 64'd0);
      @(posedge clk); #1;
      accCnt = 0; issCnt = 0; rdCnt = 0;
   endtask

   task automatic checkOutputsZero(input string tag);
      check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
      check({tag, "_en_mac"}, 64'(acc.EN_mac), 64'd0);
      check({tag, "_mac_vecA"}, acc.mac_vecA, 64'd0);
      check({tag, "_en_readmem"}, 64'(acc.EN_readMem), 64'd0);
      check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
      check({tag, "_res_data"}, 64'(res_data), 64'd0);
      check({tag, "_res_index"}, 64'(res_index), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_batch_done"}, 64'(batch_done), 64'd0);
      check({tag, "_err_timeout"}, 64'(err_timeout), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      rv = {N{1'b1}};
      va = '0; vb = '0;
      acc.RDY_mac = 1'b0; acc.VALID_memVal = 1'b0; acc.memVal_data = 32'd0;
      readCnt = 0; doneCnt = 0; exactGap = 1'b0;
      modelReset();
      repeat (3) @(posedge clk);
      #1 checkOutputsZero("reset");
      rv = '0;
      rst_n = 1'b1;

      // Back-to-back requests from everyone with unit operands
      issuePhase(1'b1, 1'b0, 64);
      drainAndRead();
      // Random requests, a 10-cycle accelerator stall and a stray result beat
      issuePhase(1'b0, 1'b1, 64);
      drainAndRead();
      issuePhase(1'b0, 1'b0, 64);
      drainAndRead();

      // Accelerator never drains: sticky timeout, no read trigger
      begin
         int r0;
         r0 = readCnt;
         issuePhase(1'b1, 1'b0, 64);
         rv = '0;
         repeat (15) @(posedge clk);
         #1 check("timeout_not_yet", 64'(err_timeout), 64'd0);
         @(posedge clk);
         #1 check("timeout_set", 64'(err_timeout), 64'd1);
         repeat (20) @(posedge clk);
         #1 check("timeout_sticky", 64'(err_timeout), 64'd1);
         check("timeout_no_readmem", 64'(readCnt), 64'(r0));
         check("timeout_busy", 64'(busy), 64'd1);
      end
      rst_n = 1'b0;
      modelReset();
      #1 checkOutputsZero("timeout_rst");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset in the middle of a batch, then a clean batch from slot 0 / pointer 0
      issuePhase(1'b0, 1'b0, 20);
      rv = '0;
      rst_n = 1'b0;
      modelReset();
      #1 checkOutputsZero("midbatch_rst");
      @(posedge clk);
      #1 checkOutputsZero("midbatch_rst_edge");
      rst_n = 1'b1;
      issuePhase(1'b1, 1'b0, 64);
      check("first_grant_after_rst", 64'(expId[0]), 64'd0);
      drainAndRead();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
